// File: rtl/simple_mem_responder.sv
// simple_mem_responder
//   Responder end of the processor memory bus. It holds a 2^ADDR_W x DATA_W
//   synchronous RAM and works in three modes:
//     CLEAR : after reset, writes CLEAR_VAL to every word, one word per cycle.
//     RUN   : serves processor reads (1-cycle registered latency) and writes.
//     LOAD  : the host loader writes words over a valid/ready handshake.
//   The processor is held off (cpu_hold = 1) in CLEAR and LOAD.
//
//   Optional feature macro: SIMPLE_MEM_WR_FWD_EN
//     defined   : a RUN write cycle returns the new data on m_q (write-first).
//     undefined : a RUN write cycle returns the old RAM word on m_q (read-first).
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   m_addr    in   processor address
//   m_data    in   processor write data
//   m_rw      in   1 = write, 0 = read
//   m_q       out  registered read data
//   cpu_hold  out  high whenever not in RUN
//   ld_start  in   pulse in RUN: enter LOAD
//   ld_valid  in   loader word valid
//   ld_ready  out  loader may transfer (high in LOAD)
//   ld_addr   in   loader write address
//   ld_data   in   loader write data
//   ld_done   in   pulse in LOAD: return to RUN
//   busy_cnt  out  current clear-sweep address

module simple_mem_responder #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] CLEAR_VAL = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_rw,
    output logic [DATA_W-1:0] m_q,
    output logic              cpu_hold,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic [ADDR_W-1:0] busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_q;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_sweep_last;

    assign w_sweep_last = (r_cnt == {ADDR_W{1'b1}});

    // State register and sweep counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            // The counter wraps back to 0 on the last sweep write, so it
            // already reads 0 when RUN is entered.
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CLEAR: if (w_sweep_last) w_next_state = ST_RUN;
            ST_RUN:   if (ld_start)     w_next_state = ST_LOAD;
            ST_LOAD:  if (ld_done)      w_next_state = ST_RUN;
            default:                    w_next_state = ST_CLEAR;
        endcase
    end

    // Single RAM write port; the state selects which source owns it.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cnt;
        w_wdata = CLEAR_VAL;
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wdata = CLEAR_VAL;
            end
            ST_RUN: begin
                w_we    = m_rw;
                w_waddr = m_addr;
                w_wdata = m_data;
            end
            ST_LOAD: begin
                w_we    = ld_valid;
                w_waddr = ld_addr;
                w_wdata = ld_data;
            end
            default: begin
                w_we    = 1'b0;
            end
        endcase
    end

    // RAM array: not reset, the CLEAR sweep initialises it.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read data register: only updated in RUN, holds its value otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (r_state == ST_RUN) begin
`ifdef SIMPLE_MEM_WR_FWD_EN
            if (m_rw) begin
                r_q <= m_data;
            end else begin
                r_q <= r_mem[m_addr];
            end
`else
            // Non-blocking read sees the pre-write word on a write cycle.
            r_q <= r_mem[m_addr];
`endif
        end
    end

    assign m_q      = r_q;
    assign cpu_hold = (r_state != ST_RUN);
    assign ld_ready = (r_state == ST_LOAD);
    assign busy_cnt = r_cnt;

endmodule

// File: tb/tb_simple_mem_responder.sv
module tb_simple_mem_responder;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4096;
`ifdef SIMPLE_MEM_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_rw = 1'b0;
    logic [DATA_W-1:0] m_q;
    logic              cpu_hold;
    logic              ld_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_done = 1'b0;
    logic [ADDR_W-1:0] busy_cnt;

    always #5 clock = ~clock;

    simple_mem_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CLEAR_VAL(16'h0000)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .m_addr  (m_addr),
        .m_data  (m_data),
        .m_rw    (m_rw),
        .m_q     (m_q),
        .cpu_hold(cpu_hold),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .ld_done (ld_done),
        .busy_cnt(busy_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: words in an array, sweep tracked as words remaining,
    // loader session as a flag.
    logic [DATA_W-1:0] mdl_mem [0:DEPTH-1];
    logic [DATA_W-1:0] mdl_q = '0;
    logic [DATA_W-1:0] mdl_old;
    int                sweep_left = DEPTH;
    bit                loading = 1'b0;
    bit                mdl_ok = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            sweep_left = DEPTH;
            loading    = 1'b0;
            mdl_q      = '0;
            mdl_ok     = 1'b1;
        end else if (mdl_ok) begin
            if (sweep_left > 0) begin
                mdl_mem[DEPTH - sweep_left] = 16'h0000;
                sweep_left--;
            end else if (loading) begin
                if (ld_valid) mdl_mem[ld_addr] = ld_data;
                if (ld_done) loading = 1'b0;
            end else begin
                mdl_old = mdl_mem[m_addr];
                if (m_rw) mdl_mem[m_addr] = m_data;
                mdl_q = (m_rw && FWD) ? m_data : mdl_old;
                if (ld_start) loading = 1'b1;
            end
        end
        if (mdl_ok) begin
            #1;
            check("mdl_m_q",      32'(m_q),      32'(mdl_q));
            check("mdl_cpu_hold", 32'(cpu_hold), 32'((sweep_left != 0) || loading));
            check("mdl_ld_ready", 32'(ld_ready), 32'(loading));
            check("mdl_busy_cnt", 32'(busy_cnt), 32'((DEPTH - sweep_left) % DEPTH));
        end
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        m_rw = 1'b1; m_addr = a; m_data = d;
        tick();
        m_rw = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string name);
        m_rw = 1'b0; m_addr = a;
        tick();
        check(name, 32'(m_q), 32'(exp));
    endtask

    task automatic sweep_count(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (cpu_hold && n < 5000);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        check({tag, "_busy_cnt"}, 32'(busy_cnt), 32'd0);
        check({tag, "_m_q"},      32'(m_q),      32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    int n;
    int rdy_cnt;
    logic [ADDR_W-1:0] la [0:2];
    logic [DATA_W-1:0] ldv [0:2];

    initial begin
        la[0] = 12'h000; ldv[0] = 16'h4001;
        la[1] = 12'h001; ldv[1] = 16'h4802;
        la[2] = 12'h002; ldv[2] = 16'hC0D0;

        // Power-on reset and clear sweep
        #2 reset = 1'b0;
        #1 reset_checks("rst");
        #19 reset = 1'b1;
        sweep_count(n);
        check("sweep_cycles", 32'(n), 32'd4096);
        rd(12'h000, 16'h0000, "clr_rd_000");
        rd(12'h7FF, 16'h0000, "clr_rd_7ff");
        rd(12'hFFF, 16'h0000, "clr_rd_fff");

        // Processor write then read
        wr(12'h123, 16'hBEEF);
        rd(12'h123, 16'hBEEF, "rd_123");

        // Read during write
        wr(12'h010, 16'h1111);
        m_rw = 1'b1; m_addr = 12'h010; m_data = 16'h2222;
        tick();
        m_rw = 1'b0;
        check("rdw_q", 32'(m_q), FWD ? 32'h2222 : 32'h1111);
        rd(12'h010, 16'h2222, "rdw_after");

        // Loader signals outside LOAD are ignored
        ld_valid = 1'b1; ld_addr = 12'h003; ld_data = 16'h1234; ld_done = 1'b1;
        tick();
        ld_valid = 1'b0; ld_done = 1'b0;
        check("ld_outside_hold", 32'(cpu_hold), 32'd0);
        rd(12'h003, 16'h0000, "ld_outside_rd");

        // Loader session with back-to-back words, done with the last word
        wr(12'h050, 16'h5A5A);
        rd(12'h123, 16'hBEEF, "pre_load_rd");
        rdy_cnt = 0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ld_ready) rdy_cnt++;
            check("load_cpu_hold", 32'(cpu_hold), 32'd1);
            ld_valid = 1'b1; ld_addr = la[i]; ld_data = ldv[i];
            ld_done  = (i == 2);
            tick();
        end
        if (ld_ready) rdy_cnt++;
        ld_valid = 1'b0; ld_done = 1'b0;
        check("load_ready_cycles", 32'(rdy_cnt), 32'd3);
        check("load_q_held", 32'(m_q), 32'hBEEF);
        check("load_exit_hold", 32'(cpu_hold), 32'd0);
        rd(12'h000, 16'h4001, "load_rd_000");
        rd(12'h001, 16'h4802, "load_rd_001");
        rd(12'h002, 16'hC0D0, "load_rd_002");

        // Processor write dropped while in LOAD
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        m_rw = 1'b1; m_addr = 12'h050; m_data = 16'hFFFF;
        tick();
        m_rw = 1'b0;
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        check("blk_exit_hold", 32'(cpu_hold), 32'd0);
        rd(12'h050, 16'h5A5A, "blk_rd_050");

        // Reset in the middle of a LOAD session
        rd(12'h123, 16'hBEEF, "pre_rst_rd");
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_addr = 12'h005; ld_data = 16'h7777;
        tick();
        ld_valid = 1'b0;
        #1 reset = 1'b0;
        #1 reset_checks("rst_load");
        #20 reset = 1'b1;
        sweep_count(n);
        check("resweep_cycles", 32'(n), 32'd4096);
        rd(12'h000, 16'h0000, "rst_rd_000");
        rd(12'h001, 16'h0000, "rst_rd_001");
        rd(12'h002, 16'h0000, "rst_rd_002");
        rd(12'h005, 16'h0000, "rst_rd_005");
        rd(12'h050, 16'h0000, "rst_rd_050");

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simple_mem_responder.md
Name: simple_mem_responder

Overview:
- Responder end of the processor memory bus (m_addr/m_data/m_rw/m_q). Holds a 2^ADDR_W x DATA_W synchronous RAM.
- Answers processor reads with a registered 1-cycle latency and performs processor writes.
- Also owns two memory-setup phases, with the processor held off during both:
  - a post-reset clear sweep;
  - a host program-load phase using a valid/ready handshake.

Parameters:
ADDR_W, 12, address width; depth = 2^ADDR_W words
DATA_W, 16, data word width
CLEAR_VAL, 16'h0000, value written to every word during the clear sweep

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
m_addr  in  ADDR_W  processor address
m_data  in  DATA_W  processor write data
m_rw  in  1  1 = write, 0 = read
m_q  out  DATA_W  read data, registered
cpu_hold  out  1  high while not in RUN; top level gates processor exec with it
ld_start  in  1  pulse in RUN: enter LOAD
ld_valid  in  1  loader word valid
ld_ready  out  1  loader may transfer
ld_addr  in  ADDR_W  loader write address
ld_data  in  DATA_W  loader write data
ld_done  in  1  pulse in LOAD: return to RUN
busy_cnt  out  ADDR_W  current clear-sweep address, for debug

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = CLEAR, sweep counter = 0, m_q = 0, cpu_hold = 1, ld_ready = 0, busy_cnt = 0.
  - RAM contents are not reset directly; the sweep re-initialises them.
- FSM states: CLEAR, RUN, LOAD.
- CLEAR:
  - Each cycle writes CLEAR_VAL to RAM[counter], then counter increments.
  - After the write to address 2^ADDR_W-1 (counter wraps to 0), next state = RUN.
  - Sweep takes exactly 2^ADDR_W cycles (4096 at default).
  - Processor bus and loader port are ignored; ld_start is ignored.
- RUN:
  - cpu_hold = 0.
  - m_rw = 1: RAM[m_addr] <= m_data.
  - m_rw = 0: m_q <= RAM[m_addr]. m_q is valid on the edge after the address is sampled (1-cycle latency).
  - On a write cycle, m_q <= old RAM[m_addr] (read-first).
  - ld_start = 1 → LOAD next cycle. The bus operation in the same cycle still completes.
- LOAD:
  - cpu_hold = 1, ld_ready = 1.
  - ld_valid & ld_ready: RAM[ld_addr] <= ld_data. One word per cycle, back-to-back allowed.
  - Processor m_rw writes are dropped. m_q holds its last value.
  - ld_done = 1 → RUN next cycle.
  - ld_done and ld_valid both high in the same cycle: the word is written, then the state exits.
- Cross-state rules:
  - ld_valid outside LOAD: ignored, no write.
  - ld_done outside LOAD: ignored.
  - Reset asserted mid-CLEAR or mid-LOAD: immediate return to CLEAR with counter = 0, and a full sweep restarts.
- Address/width:
  - m_addr and ld_addr are used unmodified, full ADDR_W.
  - No out-of-range case exists.
  - Counter wraps modulo 2^ADDR_W.
- Only one write port is active per cycle. State decides the source: CLEAR → sweep, RUN → processor, LOAD → loader.

Optional Feature:
- Macro: SIMPLE_MEM_WR_FWD_EN.
- Defined: on a RUN cycle with m_rw = 1, m_q <= m_data (write-first forwarding).
- Undefined: read-first, m_q <= previous RAM[m_addr].
- All other behaviour is identical in both builds.

Test Plan:
- Clear sweep:
  - Stimulus: release reset; count cycles until cpu_hold falls.
  - Required: exactly 4096 cycles. A read of addresses 0, 0x7FF and 0xFFF returns 0x0000 one cycle later.
- Processor write/read:
  - Stimulus: in RUN, write 0xBEEF to 0x123; read 0x123 the next cycle.
  - Required: m_q = 0xBEEF on the edge after the read address is sampled.
- Read-during-write:
  - Stimulus: RAM[0x010] = 0x1111; write 0x2222 to 0x010.
  - Required, macro undefined: m_q = 0x1111 that edge.
  - Required, macro defined: m_q = 0x2222 that edge.
  - Both builds: a subsequent read returns 0x2222.
- Loader:
  - Stimulus: ld_start; then 3 back-to-back words (0x000 ← 0x4001, 0x001 ← 0x4802, 0x002 ← 0xC0D0); ld_done asserted together with the last word.
  - Required: ld_ready = 1 for 3 cycles and cpu_hold = 1 throughout. Readback after returning to RUN gives the three values.
- Processor write blocked in LOAD:
  - Stimulus: in LOAD, drive m_rw = 1, m_addr = 0x050, m_data = 0xFFFF.
  - Required: after RUN resumes, RAM[0x050] keeps its prior value.
- Reset mid-LOAD:
  - Stimulus: assert reset during LOAD, then release.
  - Required: cpu_hold stays 1 for 4096 cycles; previously loaded words read back 0x0000.
